// File: rtl/riscv_multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// riscv_multicycle_ctrl
//
// Control FSM for the multi-cycle RV32 subset core. Each instruction passes
// through FETCH, DECODE, EXEC, and optionally MEM and WB. The FSM drives the
// shared ALU, the register file and the single unified memory port. It stops
// in TRAP on an unsupported encoding or on a memory access that never
// completes. Only reset leaves TRAP.
//
// Ports
//   clock        in   system clock, rising edge
//   reset        in   synchronous active-high reset
//   instr[31:0]  in   instruction register contents (valid in DECODE)
//   alu_bit0     in   ALU result bit 0, the bne "not equal" flag
//   mem_ready    in   memory access completes this cycle
//   alu_sel[3:0] out  ALU operation select
//   alu_src_imm  out  ALU in2 from immediate (1) or rs2 (0)
//   imm_sel[1:0] out  immediate format: 0 I, 1 S, 2 B, 3 U
//   ir_write     out  load IR from memory read data
//   pc_write     out  update PC
//   pc_branch    out  with pc_write, PC <= PC_old + B-imm, else PC + 4
//   mem_addr_sel out  memory address from PC (0) or ALU result (1)
//   mem_read     out  memory read strobe
//   mem_write    out  memory write strobe
//   mem_byte     out  byte-wide store (sb)
//   reg_write    out  register file write enable
//   wb_sel       out  write back ALU result (0) or memory data (1)
//   retired      out  one-cycle pulse when an instruction completes
//   trap         out  sticky trap flag
//   trap_cause   out  0 illegal instruction, 1 memory timeout
//   state[2:0]   out  FETCH 0, DECODE 1, EXEC 2, MEM 3, WB 4, TRAP 7
// ---------------------------------------------------------------------------
module riscv_multicycle_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] instr,
    input  logic        alu_bit0,
    input  logic        mem_ready,
    output logic [3:0]  alu_sel,
    output logic        alu_src_imm,
    output logic [1:0]  imm_sel,
    output logic        ir_write,
    output logic        pc_write,
    output logic        pc_branch,
    output logic        mem_addr_sel,
    output logic        mem_read,
    output logic        mem_write,
    output logic        mem_byte,
    output logic        reg_write,
    output logic        wb_sel,
    output logic        retired,
    output logic        trap,
    output logic        trap_cause,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd7
    } state_e;

    typedef enum logic [3:0] {
        OP_ADD, OP_SUB, OP_ADDI, OP_XORI, OP_ANDI, OP_SLLI, OP_SRLI,
        OP_SRAI, OP_LW, OP_SW, OP_SB, OP_BNE, OP_LUI
    } op_e;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_XOR = 4'b0011;
    localparam logic [3:0] ALU_SRA = 4'b0100;
    localparam logic [3:0] ALU_SLL = 4'b0101;
    localparam logic [3:0] ALU_SRL = 4'b0110;
    localparam logic [3:0] ALU_BNE = 4'b0111;
    localparam logic [3:0] ALU_LUI = 4'b1000;

    localparam logic [1:0] IMM_I = 2'd0;
    localparam logic [1:0] IMM_S = 2'd1;
    localparam logic [1:0] IMM_B = 2'd2;
    localparam logic [1:0] IMM_U = 2'd3;

    localparam logic [7:0] TIMEOUT_W = 8'(MEM_TIMEOUT);

    state_e     state_q, state_d;
    op_e        op_q, op_d;
    logic [7:0] wait_q, wait_d;
    logic       trap_q, trap_d;
    logic       cause_q, cause_d;

    op_e        dec_op;
    logic       dec_legal;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;

    // Register and immediate fields are consumed by the datapath, not here.
    logic       unused_instr_bits;

    assign opcode            = instr[6:0];
    assign funct3            = instr[14:12];
    assign funct7            = instr[31:25];
    assign unused_instr_bits = ^{instr[24:15], instr[11:7]};

    // Instruction classifier. For the OP-IMM arithmetic forms bits 31:25 are
    // immediate bits and are ignored; for shifts they must be a valid funct7.
    always_comb begin
        dec_op    = OP_ADD;
        dec_legal = 1'b0;
        case (opcode)
            7'b0110011: begin
                if (funct3 == 3'b000 && funct7 == 7'b0000000) begin
                    dec_op = OP_ADD;  dec_legal = 1'b1;
                end else if (funct3 == 3'b000 && funct7 == 7'b0100000) begin
                    dec_op = OP_SUB;  dec_legal = 1'b1;
                end
            end
            7'b0010011: begin
                case (funct3)
                    3'b000: begin dec_op = OP_ADDI; dec_legal = 1'b1; end
                    3'b100: begin dec_op = OP_XORI; dec_legal = 1'b1; end
                    3'b111: begin dec_op = OP_ANDI; dec_legal = 1'b1; end
                    3'b001: begin
                        if (funct7 == 7'b0000000) begin
                            dec_op = OP_SLLI; dec_legal = 1'b1;
                        end
                    end
                    3'b101: begin
                        if (funct7 == 7'b0000000) begin
                            dec_op = OP_SRLI; dec_legal = 1'b1;
                        end else if (funct7 == 7'b0100000) begin
                            dec_op = OP_SRAI; dec_legal = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
            7'b0000011: begin
                if (funct3 == 3'b010) begin dec_op = OP_LW; dec_legal = 1'b1; end
            end
            7'b0100011: begin
                if (funct3 == 3'b010) begin
                    dec_op = OP_SW; dec_legal = 1'b1;
                end else if (funct3 == 3'b000) begin
                    dec_op = OP_SB; dec_legal = 1'b1;
                end
            end
            7'b1100011: begin
                if (funct3 == 3'b001) begin dec_op = OP_BNE; dec_legal = 1'b1; end
            end
            7'b0110111: begin
                dec_op = OP_LUI; dec_legal = 1'b1;
            end
            default: ;
        endcase
    end

    // Next-state logic. A memory wait ends the cycle mem_ready is seen. If
    // mem_ready arrives in the same cycle the counter equals MEM_TIMEOUT, the
    // access still completes. The wait counter restarts from zero whenever
    // the state changes.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        wait_d  = wait_q;
        trap_d  = trap_q;
        cause_d = cause_q;
        case (state_q)
            S_FETCH: begin
                if (mem_ready) begin
                    state_d = S_DECODE;
                end else if (wait_q == TIMEOUT_W) begin
                    state_d = S_TRAP;
                    trap_d  = 1'b1;
                    cause_d = 1'b1;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            S_DECODE: begin
                if (dec_legal) begin
                    op_d    = dec_op;
                    state_d = S_EXEC;
                end else begin
                    state_d = S_TRAP;
                    trap_d  = 1'b1;
                    cause_d = 1'b0;
                end
            end
            S_EXEC: begin
                case (op_q)
                    OP_LW, OP_SW, OP_SB: state_d = S_MEM;
                    OP_BNE:              state_d = S_FETCH;
                    default:             state_d = S_WB;
                endcase
            end
            S_MEM: begin
                if (mem_ready) begin
                    state_d = (op_q == OP_LW) ? S_WB : S_FETCH;
                end else if (wait_q == TIMEOUT_W) begin
                    state_d = S_TRAP;
                    trap_d  = 1'b1;
                    cause_d = 1'b1;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            S_WB:    state_d = S_FETCH;
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_FETCH;
        endcase
        if (state_d != state_q) begin
            wait_d = 8'd0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_FETCH;
            op_q    <= OP_ADD;
            wait_q  <= 8'd0;
            trap_q  <= 1'b0;
            cause_q <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            wait_q  <= wait_d;
            trap_q  <= trap_d;
            cause_q <= cause_d;
        end
    end

    // Control outputs come from the state and the latched op class. Only
    // the completion strobes look at mem_ready, and the bne PC update looks
    // at alu_bit0. Reset forces every strobe low, so an instruction caught
    // mid-flight writes nothing in the reset cycle. In MEM the ALU keeps
    // computing rs1 + offset so the address stays stable while waiting.
    always_comb begin
        alu_sel      = ALU_ADD;
        alu_src_imm  = 1'b0;
        imm_sel      = IMM_I;
        ir_write     = 1'b0;
        pc_write     = 1'b0;
        pc_branch    = 1'b0;
        mem_addr_sel = 1'b0;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        mem_byte     = 1'b0;
        reg_write    = 1'b0;
        wb_sel       = 1'b0;
        retired      = 1'b0;
        if (!reset) begin
            case (state_q)
                S_FETCH: begin
                    mem_read = 1'b1;
                    ir_write = mem_ready;
                    pc_write = mem_ready;
                end
                S_EXEC: begin
                    case (op_q)
                        OP_SUB:  alu_sel = ALU_SUB;
                        OP_ADDI: alu_src_imm = 1'b1;
                        OP_XORI: begin alu_sel = ALU_XOR; alu_src_imm = 1'b1; end
                        OP_ANDI: begin alu_sel = ALU_AND; alu_src_imm = 1'b1; end
                        OP_SLLI: begin alu_sel = ALU_SLL; alu_src_imm = 1'b1; end
                        OP_SRLI: begin alu_sel = ALU_SRL; alu_src_imm = 1'b1; end
                        OP_SRAI: begin alu_sel = ALU_SRA; alu_src_imm = 1'b1; end
                        OP_LW:   alu_src_imm = 1'b1;
                        OP_SW, OP_SB: begin
                            alu_src_imm = 1'b1;
                            imm_sel     = IMM_S;
                        end
                        OP_BNE: begin
                            alu_sel   = ALU_BNE;
                            imm_sel   = IMM_B;
                            pc_write  = alu_bit0;
                            pc_branch = alu_bit0;
                            retired   = 1'b1;
                        end
                        OP_LUI: begin
                            alu_sel     = ALU_LUI;
                            alu_src_imm = 1'b1;
                            imm_sel     = IMM_U;
                        end
                        default: ;
                    endcase
                end
                S_MEM: begin
                    mem_addr_sel = 1'b1;
                    alu_src_imm  = 1'b1;
                    imm_sel      = (op_q == OP_LW) ? IMM_I : IMM_S;
                    mem_read     = (op_q == OP_LW);
                    mem_write    = (op_q == OP_SW) || (op_q == OP_SB);
                    mem_byte     = (op_q == OP_SB);
                    retired      = mem_ready && (op_q != OP_LW);
                end
                S_WB: begin
                    reg_write = 1'b1;
                    wb_sel    = (op_q == OP_LW);
                    retired   = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign trap       = trap_q;
    assign trap_cause = cause_q;
    assign state      = state_q;

endmodule

// File: tb/tb_riscv_multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// tb_riscv_multicycle_ctrl
//
// Self-checking bench for riscv_multicycle_ctrl. For every instruction, a
// reference model builds the cycle-by-cycle input and expected-output
// sequence from the instruction-level rules. The rules cover phase order,
// wait cycles, the timeout, and traps. The driver applies one cycle at a
// time and queues that cycle's expectation. The monitor pops it and
// compares against the DUT on the falling edge.
// ---------------------------------------------------------------------------
module tb_riscv_multicycle_ctrl;

    localparam int T = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] instr;
    logic        alu_bit0;
    logic        mem_ready;
    logic [3:0]  alu_sel;
    logic        alu_src_imm;
    logic [1:0]  imm_sel;
    logic        ir_write, pc_write, pc_branch, mem_addr_sel, mem_read;
    logic        mem_write, mem_byte, reg_write, wb_sel, retired;
    logic        trap, trap_cause;
    logic [2:0]  state;

    riscv_multicycle_ctrl #(.MEM_TIMEOUT(T)) dut (
        .clock        (clock),
        .reset        (reset),
        .instr        (instr),
        .alu_bit0     (alu_bit0),
        .mem_ready    (mem_ready),
        .alu_sel      (alu_sel),
        .alu_src_imm  (alu_src_imm),
        .imm_sel      (imm_sel),
        .ir_write     (ir_write),
        .pc_write     (pc_write),
        .pc_branch    (pc_branch),
        .mem_addr_sel (mem_addr_sel),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_byte     (mem_byte),
        .reg_write    (reg_write),
        .wb_sel       (wb_sel),
        .retired      (retired),
        .trap         (trap),
        .trap_cause   (trap_cause),
        .state        (state)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [2:0] state;
        logic [3:0] alu_sel;
        logic       alu_src_imm;
        logic [1:0] imm_sel;
        logic       ir_write;
        logic       pc_write;
        logic       pc_branch;
        logic       mem_addr_sel;
        logic       mem_read;
        logic       mem_write;
        logic       mem_byte;
        logic       reg_write;
        logic       wb_sel;
        logic       retired;
        logic       trap;
        logic       trap_cause;
    } out_t;

    localparam int TG_RESET  = 0;
    localparam int TG_FETCH  = 1;
    localparam int TG_DECODE = 2;
    localparam int TG_EXEC   = 3;
    localparam int TG_MEM    = 4;
    localparam int TG_WB     = 5;
    localparam int TG_TRAP   = 6;

    typedef struct {
        logic        rst;
        logic        rdy;
        logic        b0;
        logic [31:0] ins;
        bit          full;
        out_t        e;
        int          tag;
    } cyc_t;

    typedef struct {
        out_t e;
        bit   full;
        int   tag;
        int   cyc;
    } exp_t;

    typedef enum int {
        K_ADD, K_SUB, K_ADDI, K_XORI, K_ANDI, K_SLLI, K_SRLI, K_SRAI,
        K_LW, K_SW, K_SB, K_BNE, K_LUI, K_ILL
    } kind_e;

    cyc_t stim_q[$];
    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc_no   = 0;
    exp_t mon_x;

    function automatic string tag_name(input int t);
        case (t)
            TG_RESET:  return "reset";
            TG_FETCH:  return "fetch";
            TG_DECODE: return "decode";
            TG_EXEC:   return "exec";
            TG_MEM:    return "mem";
            TG_WB:     return "wb";
            default:   return "trap";
        endcase
    endfunction

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    // Instruction set rules, one per supported instruction.
    function automatic kind_e classify(input logic [31:0] w);
        logic [6:0] opc;
        logic [6:0] f7;
        logic [2:0] f3;
        opc = w[6:0];
        f3  = w[14:12];
        f7  = w[31:25];
        if (opc == 7'b0110011 && f3 == 3'b000 && f7 == 7'b0000000) return K_ADD;
        if (opc == 7'b0110011 && f3 == 3'b000 && f7 == 7'b0100000) return K_SUB;
        if (opc == 7'b0010011 && f3 == 3'b000) return K_ADDI;
        if (opc == 7'b0010011 && f3 == 3'b100) return K_XORI;
        if (opc == 7'b0010011 && f3 == 3'b111) return K_ANDI;
        if (opc == 7'b0010011 && f3 == 3'b001 && f7 == 7'b0000000) return K_SLLI;
        if (opc == 7'b0010011 && f3 == 3'b101 && f7 == 7'b0000000) return K_SRLI;
        if (opc == 7'b0010011 && f3 == 3'b101 && f7 == 7'b0100000) return K_SRAI;
        if (opc == 7'b0000011 && f3 == 3'b010) return K_LW;
        if (opc == 7'b0100011 && f3 == 3'b010) return K_SW;
        if (opc == 7'b0100011 && f3 == 3'b000) return K_SB;
        if (opc == 7'b1100011 && f3 == 3'b001) return K_BNE;
        if (opc == 7'b0110111) return K_LUI;
        return K_ILL;
    endfunction

    function automatic logic [3:0] k_alu(input kind_e k);
        case (k)
            K_SUB:   return 4'b0001;
            K_ANDI:  return 4'b0010;
            K_XORI:  return 4'b0011;
            K_SRAI:  return 4'b0100;
            K_SLLI:  return 4'b0101;
            K_SRLI:  return 4'b0110;
            K_BNE:   return 4'b0111;
            K_LUI:   return 4'b1000;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic k_imm_src(input kind_e k);
        return (k != K_ADD) && (k != K_SUB) && (k != K_BNE);
    endfunction

    function automatic logic [1:0] k_fmt(input kind_e k);
        case (k)
            K_SW, K_SB: return 2'd1;
            K_BNE:      return 2'd2;
            K_LUI:      return 2'd3;
            default:    return 2'd0;
        endcase
    endfunction

    function automatic logic [31:0] make_instr(input kind_e k);
        logic [4:0]  rd, rs1, rs2;
        logic [11:0] imm;
        logic [19:0] u;
        logic [31:0] w;
        rd  = 5'($urandom);
        rs1 = 5'($urandom);
        rs2 = 5'($urandom);
        imm = 12'($urandom);
        u   = 20'($urandom);
        case (k)
            K_ADD:   w = {7'b0000000, rs2, rs1, 3'b000, rd, 7'b0110011};
            K_SUB:   w = {7'b0100000, rs2, rs1, 3'b000, rd, 7'b0110011};
            K_ADDI:  w = {imm, rs1, 3'b000, rd, 7'b0010011};
            K_XORI:  w = {imm, rs1, 3'b100, rd, 7'b0010011};
            K_ANDI:  w = {imm, rs1, 3'b111, rd, 7'b0010011};
            K_SLLI:  w = {7'b0000000, rs2, rs1, 3'b001, rd, 7'b0010011};
            K_SRLI:  w = {7'b0000000, rs2, rs1, 3'b101, rd, 7'b0010011};
            K_SRAI:  w = {7'b0100000, rs2, rs1, 3'b101, rd, 7'b0010011};
            K_LW:    w = {imm, rs1, 3'b010, rd, 7'b0000011};
            K_SW:    w = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
            K_SB:    w = {imm[11:5], rs2, rs1, 3'b000, imm[4:0], 7'b0100011};
            K_BNE:   w = {imm[11:5], rs2, rs1, 3'b001, imm[4:0], 7'b1100011};
            K_LUI:   w = {u, rd, 7'b0110111};
            default: w = $urandom;
        endcase
        return w;
    endfunction

    task automatic push_cyc(input logic rst, input logic rdy, input logic b0,
                            input logic [31:0] ins, input bit full,
                            input out_t e, input int tag);
        cyc_t c;
        c.rst  = rst;
        c.rdy  = rdy;
        c.b0   = b0;
        c.ins  = ins;
        c.full = full;
        c.e    = e;
        c.tag  = tag;
        stim_q.push_back(c);
    endtask

    // A reset cycle must force every strobe low. The state and trap
    // registers only change at the edge, so they are not checked here.
    task automatic model_reset(input int n, input logic [31:0] ins);
        out_t e;
        e = '0;
        for (int i = 0; i < n; i++) push_cyc(1'b1, rbit(), rbit(), ins, 1'b0, e, TG_RESET);
    endtask

    task automatic model_trap(input logic cause, input logic [31:0] ins);
        out_t e;
        e = '0;
        e.state      = 3'd7;
        e.trap       = 1'b1;
        e.trap_cause = cause;
        for (int i = 0; i < 3; i++) push_cyc(1'b0, rbit(), rbit(), ins, 1'b1, e, TG_TRAP);
        model_reset(1, ins);
    endtask

    // One instruction. fw and mw are the wait cycles before mem_ready in
    // FETCH and MEM. Waits beyond T end in a timeout trap.
    task automatic model_instr(input logic [31:0] ins, input int fw, input int mw, input logic b0);
        kind_e k;
        out_t  e;
        logic  rdy;
        bit    is_ld, is_st;
        k     = classify(ins);
        is_ld = (k == K_LW);
        is_st = (k == K_SW) || (k == K_SB);
        for (int i = 0; i <= T; i++) begin
            rdy = (i == fw);
            e = '0;
            e.state    = 3'd0;
            e.mem_read = 1'b1;
            e.ir_write = rdy;
            e.pc_write = rdy;
            push_cyc(1'b0, rdy, rbit(), ins, 1'b1, e, TG_FETCH);
            if (rdy) break;
        end
        if (fw > T) begin
            model_trap(1'b1, ins);
            return;
        end
        e = '0;
        e.state = 3'd1;
        push_cyc(1'b0, rbit(), rbit(), ins, 1'b1, e, TG_DECODE);
        if (k == K_ILL) begin
            model_trap(1'b0, ins);
            return;
        end
        e = '0;
        e.state       = 3'd2;
        e.alu_sel     = k_alu(k);
        e.alu_src_imm = k_imm_src(k);
        e.imm_sel     = k_fmt(k);
        if (k == K_BNE) begin
            e.pc_write  = b0;
            e.pc_branch = b0;
            e.retired   = 1'b1;
        end
        push_cyc(1'b0, rbit(), (k == K_BNE) ? b0 : rbit(), ins, 1'b1, e, TG_EXEC);
        if (k == K_BNE) return;
        if (is_ld || is_st) begin
            for (int i = 0; i <= T; i++) begin
                rdy = (i == mw);
                e = '0;
                e.state        = 3'd3;
                e.mem_addr_sel = 1'b1;
                e.alu_src_imm  = 1'b1;
                e.imm_sel      = k_fmt(k);
                e.mem_read     = is_ld;
                e.mem_write    = is_st;
                e.mem_byte     = (k == K_SB);
                e.retired      = rdy && is_st;
                push_cyc(1'b0, rdy, rbit(), ins, 1'b1, e, TG_MEM);
                if (rdy) break;
            end
            if (mw > T) begin
                model_trap(1'b1, ins);
                return;
            end
            if (is_st) return;
        end
        e = '0;
        e.state     = 3'd4;
        e.reg_write = 1'b1;
        e.wb_sel    = is_ld;
        e.retired   = 1'b1;
        push_cyc(1'b0, rbit(), rbit(), ins, 1'b1, e, TG_WB);
    endtask

    task automatic applyStimulus(input cyc_t c);
        exp_t x;
        @(posedge clock);
        #1;
        reset     = c.rst;
        mem_ready = c.rdy;
        alu_bit0  = c.b0;
        instr     = c.ins;
        x.e    = c.e;
        x.full = c.full;
        x.tag  = c.tag;
        x.cyc  = cyc_no;
        cyc_no++;
        exp_q.push_back(x);
    endtask

    task automatic checkOutput(input exp_t x);
        out_t act, req;
        act.state        = state;
        act.alu_sel      = alu_sel;
        act.alu_src_imm  = alu_src_imm;
        act.imm_sel      = imm_sel;
        act.ir_write     = ir_write;
        act.pc_write     = pc_write;
        act.pc_branch    = pc_branch;
        act.mem_addr_sel = mem_addr_sel;
        act.mem_read     = mem_read;
        act.mem_write    = mem_write;
        act.mem_byte     = mem_byte;
        act.reg_write    = reg_write;
        act.wb_sel       = wb_sel;
        act.retired      = retired;
        act.trap         = trap;
        act.trap_cause   = trap_cause;
        req = x.e;
        if (!x.full) begin
            act.state = '0; act.trap = 1'b0; act.trap_cause = 1'b0;
            req.state = '0; req.trap = 1'b0; req.trap_cause = 1'b0;
        end
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("[TB] FAIL %s@%0d: actual st=%0d alu=%b src=%b imm=%0d ctl=%b, required st=%0d alu=%b src=%b imm=%0d ctl=%b (ctl: ir pc br as rd wr by rw wb ret trap cause)",
                     tag_name(x.tag), x.cyc, act.state, act.alu_sel, act.alu_src_imm, act.imm_sel, act[11:0],
                     req.state, req.alu_sel, req.alu_src_imm, req.imm_sel, req[11:0]);
        end
    endtask

    // Monitor: compares each queued expectation on the falling edge.
    always @(negedge clock) begin
        if (exp_q.size() > 0) begin
            mon_x = exp_q.pop_front();
            checkOutput(mon_x);
        end
    end

    // Watchdog so a stuck run still ends with a report.
    initial begin
        repeat (20000) @(posedge clock);
        $display("[TB] FAIL watchdog: cycle budget exhausted, %0d cycles still queued", stim_q.size());
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    // Stimulus: directed scenarios first, then randomized instructions.
    initial begin
        kind_e       k;
        logic [31:0] w;
        int          fw, mw;
        reset     = 1'b1;
        instr     = 32'h0;
        alu_bit0  = 1'b0;
        mem_ready = 1'b0;

        model_reset(2, 32'h0);
        model_instr(32'h002081B3, 0, 0, 1'b0);
        model_instr(32'h4032D293, 0, 0, 1'b0);
        model_instr(32'h402081B3, 0, 0, 1'b0);
        model_instr(32'h00208223, 0, 3, 1'b0);
        model_instr(32'h00209463, 0, 0, 1'b1);
        model_instr(32'h00209463, 0, 0, 1'b0);
        model_instr(32'h0000007F, 0, 0, 1'b0);
        model_instr(32'h002081B3, T + 1, 0, 1'b0);
        model_instr(32'h002081B3, T, 0, 1'b0);
        model_instr(32'h0040A183, 1, T, 1'b0);
        model_instr(32'h0040A183, 0, T + 1, 1'b0);
        model_instr(32'h0020A223, 2, T + 1, 1'b0);
        model_instr(32'h022081B3, 0, 0, 1'b0);
        model_instr(32'h00208463, 0, 0, 1'b0);
        model_instr(32'h0000A183, 0, 0, 1'b0);
        model_instr(32'h0070D293, 0, 0, 1'b0);
        model_instr(32'h000231B7, 0, 0, 1'b0);
        model_instr(32'h002081B3, 0, 0, 1'b0);
        void'(stim_q.pop_back());
        model_reset(1, 32'h002081B3);

        for (int n = 0; n < 60; n++) begin
            k = kind_e'($urandom_range(0, 13));
            if (k == K_ILL && rbit()) begin
                w = make_instr(kind_e'($urandom_range(0, 12)));
                case ($urandom_range(0, 3))
                    0:       w[25] = ~w[25];
                    1:       w[30] = ~w[30];
                    2:       w[12] = ~w[12];
                    default: w[13] = ~w[13];
                endcase
            end else begin
                w = make_instr(k);
            end
            fw = ($urandom_range(0, 11) == 0) ? T + 1 : int'($urandom_range(0, 2));
            mw = ($urandom_range(0, 7) == 0) ? int'($urandom_range(T, T + 1)) : int'($urandom_range(0, 2));
            model_instr(w, fw, mw, rbit());
            if ($urandom_range(0, 9) == 0) begin
                void'(stim_q.pop_back());
                model_reset(1, w);
            end
        end

        while (stim_q.size() > 0) begin
            applyStimulus(stim_q.pop_front());
        end
        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clock);
        if (exp_q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL drain: %0d expectations pending, required 0", exp_q.size());
        end
        @(posedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
